noc_writer_mvc: RTL and testbench
=================================

// Module: noc_writer_mvc
// PURPOSE
//  Parametrised successor of the fabric-port NoC writer. Pops flits from the
//  fabric-port afifo (1-cycle read latency) into a 2-entry holding buffer and
//  injects them into one NoC router input port. Keeps one credit counter per VC.
//  Picks the VC per packet (fixed or taken from the head flit), locks it head->tail,
//  and flags credit overflow.
// PARAMETERS
//  WIDTH         16  flit width; [W-1]=valid [W-2]=head [W-3]=tail [W-4 -: VCW]=vc
//  N             16  router count (dest field width = clog2(N); passed through)
//  NUM_VC         2  virtual channels; VCW = max(1,clog2(NUM_VC))
//  DEPTH_PER_VC  10  downstream buffer depth per VC = credit reset value
//  VC_MODE        0  0: every packet on ASSIGNED_VC; 1: VC from head flit vc field
//  ASSIGNED_VC    0  VC used when VC_MODE=0
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous, active-high reset
//  i_data_in     in   WIDTH    afifo read data, valid the cycle after i_read_en
//  i_ready_in    in   1        afifo not empty
//  i_read_en     out  1        afifo pop request
//  o_flit_out    out  WIDTH    flit to router; [W-1] is the valid strobe
//  o_credits_in  in   NUM_VC   1-cycle credit-return pulse per VC
//  o_credit_err  out  1        sticky: a credit arrived on a VC already at DEPTH_PER_VC
//  o_pkt_active  out  1        head sent, tail not yet sent (VC locked)
// BEHAVIOUR
//  Reset: buffer empty, rd_pending=0, credits[v]=DEPTH_PER_VC, lock cleared,
//   o_credit_err=0. Comb outputs i_read_en=0, o_flit_out=0, o_pkt_active=0 during rst.
//  Counter width CW=clog2(DEPTH_PER_VC+1).
//  Read: i_read_en = i_ready_in & (occ + rd_pending - send < 2). occ = buffer count.
//   rd_pending <= i_read_en. When rd_pending=1, i_data_in is written to the buffer tail.
//  Drop: a buffered flit with valid bit 0 is popped without being sent (no credit used).
//  VC select for the buffer-head flit:
//   - head flit: VC_MODE=0 -> ASSIGNED_VC; VC_MODE=1 -> vc field (value >=NUM_VC
//     wraps modulo NUM_VC).
//   - non-head flit: uses the locked VC.
//  send = head flit valid & credits[sel_vc] != 0. The buffer pops on send.
//   Min latency i_read_en -> o_flit_out valid = 2 cycles. Sustained rate 1 flit/cycle.
//  o_flit_out = send ? {1'b1, head, tail, sel_vc, rest} : '0
//   (the vc field is overwritten with sel_vc).
//  Lock: a head send without tail sets lock=sel_vc and o_pkt_active=1. A tail send clears it.
//   A head+tail flit never locks. A head arriving while locked starts a new packet
//   (relock; no error).
//  Credits, per VC each cycle:
//   - credit & send on v -> unchanged
//   - credit only -> +1, saturating at DEPTH_PER_VC; at saturation set o_credit_err
//   - send only -> -1 (send never occurs at 0)
//  Stall: if credits[sel_vc]==0 the head flit waits. Reads continue until occ=2.
//   There is no VC reordering (head-of-line blocking is accepted).
//  rst mid-packet: buffered and pending flits are discarded and the lock is cleared.
//   The afifo data returned the cycle after rst is ignored.
// TESTING
//  T1 VC_MODE=0, DEPTH=10, 12 single-flit packets queued, no credits
//   -> exactly 10 sent, then stall with occ=2. One credit pulse -> 1 more sent 1 cycle later.
//  T2 back-to-back 8-flit packet, ample credits, i_ready_in=1
//   -> first valid 2 cycles after the first i_read_en, then 8 consecutive valid cycles.
//  T3 VC_MODE=1: head vc=1, body vc field=0, tail
//   -> all 3 flits out with vc=1 and credits[1] -= 3. o_pkt_active is 1 from the head
//   to the tail cycle.
//  T4 credit pulse on VC0 in the same cycle as a send on VC0 -> credits[0] unchanged.
//   Credit on VC1 at 10 -> stays 10 and o_credit_err=1 until rst.
//  T5 invalid flit (bit W-1=0) between two valid flits
//   -> only 2 flits out and 2 credits consumed.
//  T6 rst asserted after a head on VC1
//   -> next cycle o_flit_out=0, o_pkt_active=0, credits=10. A new packet on VC0 proceeds.

Source files
------------

// File: rtl/noc_writer_mvc.sv
// noc_writer_mvc: pops flits from the fabric-port afifo into a 2-entry holding
// buffer and injects them into one NoC router input port. One credit counter
// per VC, VC chosen per packet (fixed or from the head flit) and locked from
// head to tail. A credit returned to a VC that is already full sets a sticky
// error flag.
module noc_writer_mvc #(
  parameter int WIDTH        = 16,
  parameter int N            = 16,
  parameter int NUM_VC       = 2,
  parameter int DEPTH_PER_VC = 10,
  parameter int VC_MODE      = 0,
  parameter int ASSIGNED_VC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i_data_in,
  input  logic              i_ready_in,
  output logic              i_read_en,
  output logic [WIDTH-1:0]  o_flit_out,
  input  logic [NUM_VC-1:0] o_credits_in,
  output logic              o_credit_err,
  output logic              o_pkt_active
);

  localparam int VCW   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CW    = $clog2(DEPTH_PER_VC + 1);
  localparam int DESTW = (N > 1) ? $clog2(N) : 1;
  localparam int PAYW  = WIDTH - 3 - VCW - DESTW;

  // Holding buffer: entry 0 is always the oldest flit.
  logic [WIDTH-1:0]  buf_q [2];
  logic [1:0]        occ;
  logic              rd_pending;
  logic [CW-1:0]     credits [NUM_VC];
  logic [VCW-1:0]    lock_vc;
  logic              lock_active;
  logic              credit_err;

  logic [WIDTH-1:0]  head_flit;
  logic              is_head;
  logic              is_tail;
  logic [VCW-1:0]    sel_vc;
  logic              send;
  logic              drop;
  logic              pop;
  logic [NUM_VC-1:0] send_vc;

  // Head-flit VC field folded into the legal VC range.
  function automatic logic [VCW-1:0] wrap_vc(input logic [VCW-1:0] v);
    return VCW'(int'(v) % NUM_VC);
  endfunction

  // Next credit count: a credit and a send in the same cycle cancel out,
  // a lone credit saturates at the downstream depth.
  function automatic logic [CW-1:0] cred_next(input logic [CW-1:0] c,
                                              input logic cr, input logic snd);
    logic [CW-1:0] r;
    r = c;
    if (cr && !snd && (c != CW'(DEPTH_PER_VC))) r = c + 1'b1;
    else if (!cr && snd)                        r = c - 1'b1;
    return r;
  endfunction

  // A lone credit arriving on a full counter means the downstream over-returned.
  function automatic logic cred_ovf(input logic [CW-1:0] c,
                                    input logic cr, input logic snd);
    return cr && !snd && (c == CW'(DEPTH_PER_VC));
  endfunction

  // VC selection, send/drop decision, afifo read request and outgoing flit.
  always_comb begin
    head_flit = buf_q[0];
    is_head   = head_flit[WIDTH-2];
    is_tail   = head_flit[WIDTH-3];
    sel_vc    = lock_vc;
    if (is_head) begin
      if (VC_MODE != 0) sel_vc = wrap_vc(head_flit[WIDTH-4 -: VCW]);
      else              sel_vc = VCW'(ASSIGNED_VC);
    end
    send = !rst && (occ != 2'd0) && head_flit[WIDTH-1] && (credits[sel_vc] != '0);
    drop = !rst && (occ != 2'd0) && !head_flit[WIDTH-1];
    pop  = send || drop;
    send_vc = '0;
    for (int v = 0; v < NUM_VC; v++) send_vc[v] = send && (sel_vc == VCW'(v));
    // Slots already committed (buffered + in flight) minus the one leaving now.
    i_read_en = !rst && i_ready_in &&
                (({1'b0, occ} + {2'b00, rd_pending}) < (3'd2 + {2'b00, send}));
    o_flit_out = '0;
    if (send) begin
      o_flit_out = {1'b1, is_head, is_tail, sel_vc,
                    head_flit[WIDTH-4-VCW -: DESTW], head_flit[PAYW-1:0]};
    end
    // Active from the head send through the tail send; a new head restarts it.
    o_pkt_active = !rst && ((send && is_head && !is_tail) ||
                            (lock_active && !(send && is_head)));
    o_credit_err = credit_err;
  end

  // Control state: occupancy, read pipeline, VC lock, credit counters, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ         <= 2'd0;
      rd_pending  <= 1'b0;
      lock_active <= 1'b0;
      lock_vc     <= '0;
      credit_err  <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) credits[v] <= CW'(DEPTH_PER_VC);
    end else begin
      rd_pending <= i_read_en;
      occ        <= occ - {1'b0, pop} + {1'b0, rd_pending};
      if (send) begin
        if (is_head) begin
          lock_active <= !is_tail;
          if (!is_tail) lock_vc <= sel_vc;
        end else if (is_tail) begin
          lock_active <= 1'b0;
        end
      end
      for (int v = 0; v < NUM_VC; v++) begin
        credits[v] <= cred_next(credits[v], o_credits_in[v], send_vc[v]);
        if (cred_ovf(credits[v], o_credits_in[v], send_vc[v])) credit_err <= 1'b1;
      end
    end
  end

  // Buffer data: shift on pop, afifo data lands in the first free slot.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (occ == 2'd2) begin
        buf_q[0] <= buf_q[1];
        if (rd_pending) buf_q[1] <= i_data_in;
      end else if (rd_pending) begin
        buf_q[0] <= i_data_in;
      end
    end else if (rd_pending) begin
      if (occ == 2'd0) buf_q[0] <= i_data_in;
      else             buf_q[1] <= i_data_in;
    end
  end

endmodule

// File: tb/tb_noc_writer_mvc.sv
// Scoreboard bench for noc_writer_mvc: two instances (fixed-VC and head-VC
// mode) share one afifo model; expected flits are queued at stimulus time and
// a negedge monitor compares whatever the active instance emits.
module tb_noc_writer_mvc;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] flit;
    logic         act;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic [W-1:0] data_in;
  logic ready;
  logic [1:0] cred;
  logic re0, re1, err0, err1, act0, act1;
  logic [W-1:0] f0, f1;
  logic re_a, act_a;
  logic [W-1:0] f_a, f_i;

  exp_t exp_q[$];
  logic [W-1:0] fifo_q[$];
  exp_t e;
  logic re_s;
  int compared = 0;
  int mismatched = 0;
  int sent = 0;
  int cyc = 0;
  int first_re = -1;
  int first_vld = -1;
  int last_vld = -1;
  int found;

  always #5 clk = ~clk;

  assign re_a  = sel ? re1 : re0;
  assign act_a = sel ? act1 : act0;
  assign f_a   = sel ? f1 : f0;
  assign f_i   = sel ? f0 : f1;

  noc_writer_mvc #(.WIDTH(16), .N(16), .NUM_VC(2), .DEPTH_PER_VC(10),
                   .VC_MODE(0), .ASSIGNED_VC(0)) dut0 (
    .clk(clk), .rst(rst), .i_data_in(data_in), .i_ready_in(ready & ~sel),
    .i_read_en(re0), .o_flit_out(f0), .o_credits_in(sel ? 2'b00 : cred),
    .o_credit_err(err0), .o_pkt_active(act0));

  noc_writer_mvc #(.WIDTH(16), .N(16), .NUM_VC(2), .DEPTH_PER_VC(10),
                   .VC_MODE(1), .ASSIGNED_VC(0)) dut1 (
    .clk(clk), .rst(rst), .i_data_in(data_in), .i_ready_in(ready & sel),
    .i_read_en(re1), .o_flit_out(f1), .o_credits_in(sel ? cred : 2'b00),
    .o_credit_err(err1), .o_pkt_active(act1));

  task automatic chk(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] in, input logic [W-1:0] outv,
                      input logic a, input logic expect_out);
    fifo_q.push_back(in);
    if (expect_out) exp_q.push_back('{flit: outv, act: a});
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // afifo model: a read seen this cycle returns data one cycle later.
  always begin
    @(negedge clk);
    re_s = re_a;
    if (re_s && first_re < 0) first_re = cyc;
    @(posedge clk);
    #2;
    if (re_s) begin
      if (fifo_q.size() > 0) data_in = fifo_q.pop_front();
      else begin
        compared++;
        mismatched++;
        $display("FAIL read_when_empty: read_en=1 with afifo empty");
      end
    end
    ready = (fifo_q.size() != 0);
  end

  // Output monitor.
  always @(negedge clk) begin
    if (f_a[W-1]) begin
      sent++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_flit: got %h, none expected", f_a);
      end else begin
        e = exp_q.pop_front();
        chk("flit", f_a, e.flit);
        chk("pkt_active", act_a, e.act);
      end
    end
    if (f_i[W-1]) begin
      compared++;
      mismatched++;
      $display("FAIL idle_instance_flit: got %h, expected 0", f_i);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; cred = 2'b00; data_in = '0; ready = 1'b0;

    // T1: 12 single-flit packets (vc field 1 is overwritten with VC 0), no credits.
    for (int i = 0; i < 12; i++)
      push(16'hF000 | 16'(12'h100 + i), 16'hE000 | 16'(12'h100 + i), 1'b0, 1'b1);
    repeat (3) tick();
    chk("rst_read_en", re0, 0);
    chk("rst_flit", f0, 0);
    chk("rst_pkt_active", act0, 0);
    chk("rst_credit_err", err0, 0);
    rst = 1'b0;
    chk("rst_credits0", dut0.credits[0], 10);
    repeat (25) tick();
    chk("t1_sent", sent, 10);
    chk("t1_occ", dut0.occ, 2);
    chk("t1_credits0", dut0.credits[0], 0);
    chk("t1_afifo_left", fifo_q.size(), 0);
    cred = 2'b01;
    tick();
    cred = 2'b00;
    chk("t1_not_before_credit", sent, 10);
    chk("t1_send_after_credit", f0[W-1], 1);
    tick();
    chk("t1_sent_11", sent, 11);
    cred = 2'b01;
    tick();
    cred = 2'b00;
    repeat (3) tick();
    chk("t1_sent_12", sent, 12);
    chk("t1_scoreboard_empty", exp_q.size(), 0);

    // T2: 8-flit packet, ample credits.
    do_reset();
    sent = 0; first_re = -1; first_vld = -1; last_vld = -1;
    push(16'hC201, 16'hC201, 1'b1, 1'b1);
    for (int i = 2; i < 8; i++) push(16'h8200 | 16'(i), 16'h8200 | 16'(i), 1'b1, 1'b1);
    push(16'hA208, 16'hA208, 1'b1, 1'b1);
    wait_drain(40);
    chk("t2_latency", first_vld - first_re, 2);
    chk("t2_burst_span", last_vld - first_vld, 7);
    chk("t2_sent", sent, 8);
    chk("t2_credits0", dut0.credits[0], 2);
    chk("t2_pkt_active_after", act0, 0);

    // T4: overflow credit on VC1, then credit+send on VC0 in one cycle.
    cred = 2'b10;
    tick();
    cred = 2'b00;
    tick();
    chk("t4_credit_err", err0, 1);
    chk("t4_credits1_sat", dut0.credits[1], 10);
    push(16'hE401, 16'hE401, 1'b0, 1'b1);
    found = 0;
    for (int n = 0; n < 10 && found == 0; n++) begin
      tick();
      if (f0[W-1]) begin
        found = 1;
        cred = 2'b01;
        tick();
        cred = 2'b00;
      end
    end
    chk("t4_send_seen", found, 1);
    chk("t4_credits0_unchanged", dut0.credits[0], 2);
    tick();
    chk("t4_credit_err_sticky", err0, 1);
    do_reset();
    chk("t4_err_cleared", err0, 0);
    chk("t4_credits1_reset", dut0.credits[1], 10);

    // T5: invalid flit between two valid flits is dropped.
    sent = 0;
    push(16'hE501, 16'hE501, 1'b0, 1'b1);
    push(16'h65FF, 16'h0000, 1'b0, 1'b0);
    push(16'hE502, 16'hE502, 1'b0, 1'b1);
    wait_drain(30);
    repeat (4) tick();
    chk("t5_sent", sent, 2);
    chk("t5_credits0", dut0.credits[0], 8);
    chk("t5_occ", dut0.occ, 0);

    // T3: head-VC mode; body/tail follow the head's VC.
    sel = 1'b1;
    do_reset();
    push(16'hD3A1, 16'hD3A1, 1'b1, 1'b1);
    push(16'h83A2, 16'h93A2, 1'b1, 1'b1);
    push(16'hA3A3, 16'hB3A3, 1'b1, 1'b1);
    wait_drain(30);
    tick();
    chk("t3_credits1", dut1.credits[1], 7);
    chk("t3_credits0", dut1.credits[0], 10);
    chk("t3_pkt_active_after", act1, 0);

    // T6: reset mid-packet on VC1, then a fresh packet on VC0.
    push(16'hD4B1, 16'hD4B1, 1'b1, 1'b1);
    wait_drain(30);
    chk("t6_locked", act1, 1);
    rst = 1'b1;
    tick();
    chk("t6_rst_flit", f1, 0);
    chk("t6_rst_pkt_active", act1, 0);
    rst = 1'b0;
    chk("t6_pkt_active_cleared", act1, 0);
    chk("t6_credits1_reset", dut1.credits[1], 10);
    push(16'hC4C1, 16'hC4C1, 1'b1, 1'b1);
    push(16'hB4C2, 16'hA4C2, 1'b1, 1'b1);
    wait_drain(30);
    tick();
    chk("t6_credits0", dut1.credits[0], 8);
    chk("t6_pkt_active_after", act1, 0);

    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
